fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register directly upstream of the instruction decoder (control).
- Holds the PC and issues word-addressed requests to the instruction cache, absorbing miss latency.
- Delivers one 16-bit instruction per cycle, with its PC and PC+1, to decode.
- Honours stall from the hazard unit, redirect from branch/jump resolution, and stops fetching after HLT.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_perf_ctr.sv | 23 ++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: opcodes, the bubble word and FSM state encodings.
package fetch_stage_pkg;

    localparam logic [3:0]  OP_HLT   = 4'hF;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic is_hlt(input logic [15:0] word);
        return word[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter with synchronous active-low reset.
module fetch_perf_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; handles misses, stall, redirect and HLT.
// Optional FETCH_PERF_EN adds saturating fetch and miss-cycle counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rdy,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] instr_pc1,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_miss_cyc,
`endif
    output logic            halted
);

    logic [1:0]      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic [15:0]     instr_reg, instr_next;
    logic            instr_valid_reg, instr_valid_next;
    logic [PC_W-1:0] instr_pc_reg, instr_pc_next;
    logic [PC_W-1:0] instr_pc1_reg, instr_pc1_next;

    assign pc_plus1 = pc_reg + PC_W'(1);

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_valid_next = instr_valid_reg;
        instr_pc_next    = instr_pc_reg;
        instr_pc1_next   = instr_pc1_reg;
        if (redirect_valid) begin
            // Any data returned this cycle belongs to the squashed path.
            pc_next          = redirect_pc;
            instr_next       = NOP_WORD;
            instr_valid_next = 1'b0;
            state_next       = ST_FETCH;
        end else if (!stall) begin
            if (state_reg == ST_HALTED) begin
                instr_next       = NOP_WORD;
                instr_valid_next = 1'b0;
            end else if (imem_rdy) begin
                instr_next       = imem_data;
                instr_valid_next = 1'b1;
                instr_pc_next    = pc_reg;
                instr_pc1_next   = pc_plus1;
                if (is_hlt(imem_data)) begin
                    state_next = ST_HALTED;
                end else begin
                    pc_next    = pc_plus1;
                    state_next = ST_FETCH;
                end
            end else begin
                instr_next       = NOP_WORD;
                instr_valid_next = 1'b0;
                state_next       = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_PC;
            instr_reg       <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            instr_pc_reg    <= '0;
            instr_pc1_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
            instr_pc_reg    <= instr_pc_next;
            instr_pc1_reg   <= instr_pc1_next;
        end
    end

    assign imem_req    = rst_n && (state_reg != ST_HALTED);
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_pc1   = instr_pc1_reg;
    assign halted      = (state_reg == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic hit_consume, miss_cycle;

    // A miss cycle is any unstalled request left unanswered, including the first one.
    assign hit_consume = !redirect_valid && !stall && (state_reg != ST_HALTED) && imem_rdy;
    assign miss_cycle  = !redirect_valid && !stall && (state_reg != ST_HALTED) && !imem_rdy;

    fetch_perf_ctr #(.W(32)) u_fetch_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_consume),
        .count (perf_fetch_cnt)
    );

    fetch_perf_ctr #(.W(32)) u_miss_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_cycle),
        .count (perf_miss_cyc)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc1;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_miss_cyc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .instr_pc1      (instr_pc1),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_miss_cyc  (perf_miss_cyc),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_rdy       = 1'b0;
        imem_data      = 16'h0000;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        n_cmp++; if (instr !== 16'h0000 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ifid: got %h/%b want 0000/0", instr, instr_valid); end
        n_cmp++; if (instr_pc !== 16'h0000 || instr_pc1 !== 16'h0000) begin n_bad++; $display("FAIL reset_pcs: got %h/%h want 0000/0000", instr_pc, instr_pc1); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %b want 1", imem_req); end
        $display("reset: checked");
    endtask

    task automatic test_hits();
        logic [15:0] words [3];
        words = '{16'h1123, 16'h2456, 16'h3789};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_rdy = 1'b1; imem_data = words[i]; #1;
            n_cmp++; if (imem_addr !== 16'(i)) begin n_bad++; $display("FAIL hits_addr[%0d]: got %h want %h", i, imem_addr, 16'(i)); end
            tick();
            n_cmp++; if (instr !== words[i] || instr_valid !== 1'b1) begin n_bad++; $display("FAIL hits_instr[%0d]: got %h/%b want %h/1", i, instr, instr_valid, words[i]); end
            n_cmp++; if (instr_pc !== 16'(i) || instr_pc1 !== 16'(i + 1)) begin n_bad++; $display("FAIL hits_pc[%0d]: got %h/%h want %h/%h", i, instr_pc, instr_pc1, 16'(i), 16'(i + 1)); end
            $display("hit %0d: instr=%h pc=%h pc1=%h", i, instr, instr_pc, instr_pc1);
        end
        idle();
    endtask

    task automatic test_miss();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            imem_rdy = 1'b1; imem_data = 16'h1000 + 16'(i);
            tick();
        end
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1) begin n_bad++; $display("FAIL miss_addr[%0d]: got %h/%b want 0005/1", i, imem_addr, imem_req); end
            tick();
            n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin n_bad++; $display("FAIL miss_bubble[%0d]: got %h/%b want 0000/0", i, instr, instr_valid); end
        end
        imem_rdy = 1'b1; imem_data = 16'h4ABC;
        tick();
        n_cmp++; if (instr !== 16'h4ABC || instr_valid !== 1'b1 || instr_pc !== 16'h0005 || instr_pc1 !== 16'h0006) begin
            n_bad++; $display("FAIL miss_resume: got %h/%b pc %h/%h want 4abc/1 pc 0005/0006", instr, instr_valid, instr_pc, instr_pc1);
        end
`ifdef FETCH_PERF_EN
        n_cmp++; if (perf_miss_cyc !== 32'd3) begin n_bad++; $display("FAIL perf_miss_cyc: got %0d want 3", perf_miss_cyc); end
        n_cmp++; if (perf_fetch_cnt !== 32'd6) begin n_bad++; $display("FAIL perf_fetch_cnt: got %0d want 6", perf_fetch_cnt); end
`endif
        $display("miss: resumed instr=%h pc=%h", instr, instr_pc);
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        imem_rdy = 1'b1; imem_data = 16'h1123; tick();
        imem_data = 16'h2456; tick();
        stall = 1'b1; imem_data = 16'h3789;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (imem_addr !== 16'h0002) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 0002", i, imem_addr); end
            tick();
            n_cmp++; if (instr !== 16'h2456 || instr_valid !== 1'b1 || instr_pc !== 16'h0001) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got %h/%b pc %h want 2456/1 pc 0001", i, instr, instr_valid, instr_pc);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (instr !== 16'h3789 || instr_pc !== 16'h0002 || imem_addr !== 16'h0003) begin
            n_bad++; $display("FAIL stall_release: got %h pc %h addr %h want 3789 pc 0002 addr 0003", instr, instr_pc, imem_addr);
        end
        $display("stall: released instr=%h pc=%h", instr, instr_pc);
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        imem_rdy = 1'b1; imem_data = 16'h1123; tick();
        imem_rdy = 1'b0; tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
        imem_rdy = 1'b1; imem_data = 16'h5555;
        tick();
        redirect_valid = 1'b0; stall = 1'b0; imem_data = 16'h6666;
        #1;
        n_cmp++; if (imem_addr !== 16'h0040) begin n_bad++; $display("FAIL redir_addr: got %h want 0040", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin n_bad++; $display("FAIL redir_bubble: got %h/%b want 0000/0", instr, instr_valid); end
        tick();
        n_cmp++; if (instr !== 16'h6666 || instr_pc !== 16'h0040 || instr_pc1 !== 16'h0041) begin
            n_bad++; $display("FAIL redir_target: got %h pc %h/%h want 6666 pc 0040/0041", instr, instr_pc, instr_pc1);
        end
        $display("redirect: instr=%h pc=%h", instr, instr_pc);
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        imem_rdy = 1'b1; imem_data = 16'hF000; tick();
        n_cmp++; if (instr !== 16'hF000 || instr_valid !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL halt_enter: got %h/%b halted %b req %b want f000/1 halted 1 req 0", instr, instr_valid, halted, imem_req);
        end
        imem_data = 16'h1111; tick();
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || halted !== 1'b1 || imem_addr !== 16'h0000) begin
            n_bad++; $display("FAIL halt_bubble: got %h/%b halted %b addr %h want 0000/0 halted 1 addr 0000", instr, instr_valid, halted, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0010; tick();
        redirect_valid = 1'b0; imem_data = 16'h2222;
        #1;
        n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
            n_bad++; $display("FAIL halt_exit: got halted %b req %b addr %h want 0 1 0010", halted, imem_req, imem_addr);
        end
        tick();
        n_cmp++; if (instr !== 16'h2222 || instr_pc !== 16'h0010 || instr_pc1 !== 16'h0011) begin
            n_bad++; $display("FAIL halt_resume: got %h pc %h/%h want 2222 pc 0010/0011", instr, instr_pc, instr_pc1);
        end
        $display("halt: resumed instr=%h pc=%h", instr, instr_pc);
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF; tick();
        redirect_valid = 1'b0; imem_rdy = 1'b1; imem_data = 16'h1234;
        tick();
        n_cmp++; if (instr_pc !== 16'hFFFF || instr_pc1 !== 16'h0000) begin n_bad++; $display("FAIL wrap_pcs: got %h/%h want ffff/0000", instr_pc, instr_pc1); end
        n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
        $display("wrap: pc=%h pc1=%h next=%h", instr_pc, instr_pc1, imem_addr);
        idle();
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 16'h0030; tick();
        redirect_valid = 1'b0; imem_rdy = 1'b0; tick(); tick();
        rst_n = 1'b0; tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rstmiss_req_low: got %b want 0", imem_req); end
        rst_n = 1'b1; #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmiss_restart: got req %b addr %h valid %b want 1 0000 0", imem_req, imem_addr, instr_valid);
        end
        imem_rdy = 1'b1; imem_data = 16'h7777; tick();
        n_cmp++; if (instr !== 16'h7777 || instr_pc !== 16'h0000) begin n_bad++; $display("FAIL rstmiss_fetch: got %h pc %h want 7777 pc 0000", instr, instr_pc); end
        $display("reset mid-miss: instr=%h pc=%h", instr, instr_pc);
        idle();
    endtask

    // Reference model: a PC, a halted flag and what decode should see; misses need no state of their own.
    task automatic test_random();
        logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
        logic        m_valid, m_halt;
        int          bad_before;
        bad_before = n_bad;
        do_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0; m_ipc = 16'h0000; m_ipc1 = 16'h0000;
        for (int c = 0; c < 600; c++) begin
            rst_n          = ($urandom_range(63) != 0);
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(7) == 0);
            redirect_pc    = 16'($urandom);
            imem_rdy       = ($urandom_range(2) != 0);
            imem_data      = 16'($urandom);
            if ($urandom_range(9) == 0) imem_data[15:12] = 4'hF;
            #1;
            n_cmp++; if (imem_req !== (rst_n && !m_halt)) begin n_bad++; $display("FAIL rand_req[%0d]: got %b want %b", c, imem_req, rst_n && !m_halt); end
            n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rand_addr[%0d]: got %h want %h", c, imem_addr, m_pc); end
            if (!rst_n) begin
                m_pc = 16'h0000; m_halt = 1'b0; m_instr = 16'h0000; m_valid = 1'b0; m_ipc = 16'h0000; m_ipc1 = 16'h0000;
            end else if (redirect_valid) begin
                m_pc = redirect_pc; m_halt = 1'b0; m_instr = 16'h0000; m_valid = 1'b0;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (m_halt || !imem_rdy) begin
                m_instr = 16'h0000; m_valid = 1'b0;
            end else begin
                m_instr = imem_data; m_valid = 1'b1; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1;
                if (imem_data[15:12] == 4'hF) m_halt = 1'b1;
                else m_pc = m_pc + 16'd1;
            end
            tick();
            n_cmp++; if (instr !== m_instr || instr_valid !== m_valid) begin n_bad++; $display("FAIL rand_ifid[%0d]: got %h/%b want %h/%b", c, instr, instr_valid, m_instr, m_valid); end
            n_cmp++; if (halted !== m_halt) begin n_bad++; $display("FAIL rand_halted[%0d]: got %b want %b", c, halted, m_halt); end
            if (m_valid) begin
                n_cmp++; if (instr_pc !== m_ipc || instr_pc1 !== m_ipc1) begin n_bad++; $display("FAIL rand_pcs[%0d]: got %h/%h want %h/%h", c, instr_pc, instr_pc1, m_ipc, m_ipc1); end
            end
        end
        rst_n = 1'b1;
        idle();
        $display("random: 600 cycles, %0d new mismatches", n_bad - bad_before);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_hits();
        test_miss();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid_miss();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
